// File: rtl/hilo_muldiv_if.sv
// HI/LO unit bundle: start handshake, flush, MTHI/MTLO writes, results.
// master = pipeline side, slave = hilo_muldiv.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             write_hi_en;
  logic             write_lo_en;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, op, src_a, src_b, flush,
    output write_hi_en, write_lo_en, hi_data, lo_data,
    input  start_ready, hi, lo, busy, done
  );

  modport slave (
    input  start_valid, op, src_a, src_b, flush,
    input  write_hi_en, write_lo_en, hi_data, lo_data,
    output start_ready, hi, lo, busy, done
  );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO registers with multi-cycle MULT/MULTU/DIV/DIVU engine.
// Ports: clk, resetn (async low), io (hilo_muldiv_if.slave).
module hilo_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            resetn,
  hilo_muldiv_if.slave    io
);
  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] a_q, b_q, bmag_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;

  logic busy, fin, done, accept;
  logic in_sa, in_sb, sa_q, sb_q;
  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   sh, diff;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  assign busy   = state != IDLE;
  assign fin    = busy & (cnt == '0);
  assign done   = fin & ~io.flush;
  assign accept = io.start_valid & io.start_ready;

  assign io.busy        = busy;
  assign io.done        = done;
  assign io.start_ready = resetn & ~busy & ~io.flush;

  // Operand magnitudes for the restoring divider
  assign in_sa = ~io.op[0] & io.src_a[WIDTH-1];
  assign in_sb = ~io.op[0] & io.src_b[WIDTH-1];
  assign amag  = in_sa ? -io.src_a : io.src_a;
  assign bmag  = in_sb ? -io.src_b : io.src_b;

  assign sa_q = ~op_q[0] & a_q[WIDTH-1];
  assign sb_q = ~op_q[0] & b_q[WIDTH-1];

  // One quotient bit per cycle
  assign sh    = {rem_q, quo_q[WIDTH-1]};
  assign diff  = sh - {1'b0, bmag_q};
  assign rem_n = diff[WIDTH] ? sh[WIDTH-1:0]
                             : diff[WIDTH-1:0];
  assign quo_n = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  assign ax   = {{WIDTH{sa_q}}, a_q};
  assign bx   = {{WIDTH{sb_q}}, b_q};
  assign prod = ax * bx;

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = sa_q ? -rem_q : rem_q;
        res_lo = (sa_q ^ sb_q) ? -quo_q : quo_q;
      end
    end
  end

  // Direct writes beat the engine per register
  always_comb begin
    hi_nx = hi_q;
    lo_nx = lo_q;
    if (done) begin
      hi_nx = res_hi;
      lo_nx = res_lo;
    end
    if (io.write_hi_en) hi_nx = io.hi_data;
    if (io.write_lo_en) lo_nx = io.lo_data;
  end

  assign io.hi = resetn ? hi_nx : '0;
  assign io.lo = resetn ? lo_nx : '0;

  always_comb begin
    state_n = state;
    if (io.flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (accept)
                state_n = io.op[1] ? DIV : MUL;
        MUL,
        DIV:  if (fin) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bmag_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      op_q   <= '0;
      cnt    <= '0;
    end else begin
      hi_q <= hi_nx;
      lo_q <= lo_nx;
      if (accept) begin
        op_q   <= io.op;
        a_q    <= io.src_a;
        b_q    <= io.src_b;
        bmag_q <= bmag;
        quo_q  <= amag;
        rem_q  <= '0;
        cnt    <= io.op[1] ? CW'(WIDTH)
                           : CW'(MUL_LAT - 1);
      end else if (busy && cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (state == DIV) begin
          quo_q <= quo_n;
          rem_q <= rem_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases
// plus random ops against an arithmetic reference model.
module tb_hilo_muldiv;
  localparam int W  = 32;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;

  hilo_muldiv_if #(.WIDTH(W)) io();

  hilo_muldiv #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk),
    .resetn(resetn),
    .io(io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [1:0] o,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] h,
                                output logic [W-1:0] l);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd3) begin
          p = {a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  task automatic wait_done(input int lim, output int n);
    n = 1;
    #1;
    while (io.done !== 1'b1 && n < lim) begin
      tick();
      #1;
      n++;
    end
  endtask

  task automatic start(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    io.start_valid = 1'b1;
    io.op = o;
    io.src_a = a;
    io.src_b = b;
    #1;
    chk("ready", W'(io.start_ready), W'(1));
    tick();
    io.start_valid = 1'b0;
    io.src_a = $urandom;
    io.src_b = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int n, lat;
    model(o, a, b, eh, el);
    lat = o[1] ? W + 1 : ML;
    start(o, a, b);
    chk("busy", W'(io.busy), W'(1));
    wait_done(lat + 3, n);
    chk("latency", W'(n), W'(lat));
    chk("done", W'(io.done), W'(1));
    chk("res_hi", io.hi, eh);
    chk("res_lo", io.lo, el);
    tick();
    #1;
    chk("idle", W'(io.busy), W'(0));
    chk("hold_hi", io.hi, eh);
    chk("hold_lo", io.lo, el);
    ref_hi = eh;
    ref_lo = el;
  endtask

  initial begin
    int n;
    logic [1:0] o;
    logic [W-1:0] a, b;
    io.start_valid = 1'b0;
    io.op = '0;
    io.src_a = '0;
    io.src_b = '0;
    io.flush = 1'b0;
    io.write_hi_en = 1'b1;
    io.write_lo_en = 1'b0;
    io.hi_data = 32'hFF;
    io.lo_data = '0;

    // Reset: outputs forced low, writes ignored
    #12;
    chk("rst_hi", io.hi, '0);
    chk("rst_lo", io.lo, '0);
    chk("rst_busy", W'(io.busy), W'(0));
    chk("rst_done", W'(io.done), W'(0));
    chk("rst_ready", W'(io.start_ready), W'(0));
    io.write_hi_en = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("post_ready", W'(io.start_ready), W'(1));
    chk("post_hi", io.hi, '0);

    // Directed arithmetic
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3);
    run_op(2'd1, 32'hFFFF_FFFE, 32'd3);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd3, 32'h0000_1234, 32'd0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000);

    // Random ops
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0)
          ? 32'($urandom_range(0, 5)) : $urandom;
      run_op(o, a, b);
    end

    // MTHI collides with MULTU completion
    start(2'd1, 32'd5, 32'd7);
    wait_done(ML + 3, n);
    io.write_hi_en = 1'b1;
    io.hi_data = 32'hAA;
    #1;
    chk("col_done", W'(io.done), W'(1));
    chk("col_hi", io.hi, 32'hAA);
    chk("col_lo", io.lo, 32'd35);
    tick();
    io.write_hi_en = 1'b0;
    #1;
    chk("col_hi_keep", io.hi, 32'hAA);
    chk("col_lo_keep", io.lo, 32'd35);

    // MTLO mid-DIV, then quotient lands
    start(2'd3, 32'd100, 32'd7);
    repeat (4) tick();
    io.write_lo_en = 1'b1;
    io.lo_data = 32'h77;
    #1;
    chk("mid_lo_fwd", io.lo, 32'h77);
    tick();
    io.write_lo_en = 1'b0;
    #1;
    chk("mid_lo_reg", io.lo, 32'h77);
    chk("mid_busy", W'(io.busy), W'(1));
    wait_done(W + 3, n);
    chk("mid_latency", W'(n), W'(W - 4));
    chk("mid_lo", io.lo, 32'd14);
    chk("mid_hi", io.hi, 32'd2);
    tick();
    ref_hi = 32'd2;
    ref_lo = 32'd14;

    // Flush at T+10, accept again at T+11
    start(2'd2, 32'd1000, 32'd3);
    repeat (9) tick();
    io.flush = 1'b1;
    #1;
    chk("fl_done", W'(io.done), W'(0));
    chk("fl_ready", W'(io.start_ready), W'(0));
    tick();
    io.flush = 1'b0;
    #1;
    chk("fl_busy", W'(io.busy), W'(0));
    chk("fl_hi", io.hi, ref_hi);
    chk("fl_lo", io.lo, ref_lo);
    run_op(2'd1, 32'd9, 32'd9);

    // Flush in the completion cycle
    start(2'd1, 32'd123, 32'd456);
    wait_done(ML + 3, n);
    io.flush = 1'b1;
    #1;
    chk("flc_done", W'(io.done), W'(0));
    chk("flc_hi", io.hi, ref_hi);
    chk("flc_lo", io.lo, ref_lo);
    tick();
    io.flush = 1'b0;
    #1;
    chk("flc_busy", W'(io.busy), W'(0));
    chk("flc_lo_keep", io.lo, ref_lo);

    // Reset mid-MUL
    io.write_hi_en = 1'b1;
    io.write_lo_en = 1'b1;
    io.hi_data = 32'h55;
    io.lo_data = 32'h66;
    tick();
    io.write_hi_en = 1'b0;
    io.write_lo_en = 1'b0;
    #1;
    chk("pre_hi", io.hi, 32'h55);
    start(2'd0, 32'd3, 32'd4);
    resetn = 1'b0;
    io.write_lo_en = 1'b1;
    io.lo_data = 32'h9;
    #1;
    chk("mr_hi", io.hi, '0);
    chk("mr_lo", io.lo, '0);
    chk("mr_busy", W'(io.busy), W'(0));
    chk("mr_done", W'(io.done), W'(0));
    chk("mr_ready", W'(io.start_ready), W'(0));
    tick();
    resetn = 1'b1;
    #1;
    chk("rel_hi", io.hi, '0);
    chk("rel_lo", io.lo, 32'h9);
    chk("rel_ready", W'(io.start_ready), W'(1));
    chk("rel_busy", W'(io.busy), W'(0));
    tick();
    io.write_lo_en = 1'b0;
    #1;
    chk("rel_lo_keep", io.lo, 32'h9);
    chk("rel_done", W'(io.done), W'(0));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
